// File: rtl/mips_cpu_avalon_master.sv
// Avalon-MM bus master arbitrating CPU fetch and data requests onto one port.
// Optional bus watchdog: define MIPS_AVALON_TIMEOUT_EN to abort stalled transfers.
module mips_cpu_avalon_master #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_byteenable,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] avm_address,
  output logic [3:0]  avm_byteenable,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

  state_t state;
  logic   last_data;
  logic   grant_data;
  logic   sel_data;

  // Round-robin: data only wins a tie if fetch was served last
  assign sel_data = d_req && (!i_req || !last_data);
  assign busy     = (state != IDLE);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

`ifdef MIPS_AVALON_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [CW-1:0] to_cnt;
  logic          to_hit;
  assign to_hit = (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign bus_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      last_data      <= 1'b1;
      grant_data     <= 1'b0;
      i_ack          <= 1'b0;
      i_rdata        <= '0;
      d_ack          <= 1'b0;
      d_rdata        <= '0;
      avm_address    <= '0;
      avm_byteenable <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
`ifdef MIPS_AVALON_TIMEOUT_EN
      to_cnt         <= '0;
      bus_error      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            last_data  <= sel_data;
            grant_data <= sel_data;
            if (sel_data && d_byteenable == 4'b0000) begin
              d_ack <= 1'b1;
              state <= ACK;
            end else begin
              state          <= ISSUE;
              avm_address    <= sel_data ? {d_addr[31:2], 2'b00} : {i_addr[31:2], 2'b00};
              avm_byteenable <= sel_data ? d_byteenable : 4'b1111;
              avm_read       <= !sel_data || !d_we;
              avm_write      <= sel_data && d_we;
              avm_writedata  <= sel_data ? d_wdata : 32'h0;
`ifdef MIPS_AVALON_TIMEOUT_EN
              to_cnt         <= '0;
`endif
            end
          end
        end
        ISSUE: begin
          if (!avm_waitrequest) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            state     <= ACK;
            if (grant_data) begin
              d_ack <= 1'b1;
              if (avm_read) d_rdata <= avm_readdata;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= avm_readdata;
            end
          end
`ifdef MIPS_AVALON_TIMEOUT_EN
          else if (to_hit) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            state     <= ACK;
            bus_error <= 1'b1;
            if (grant_data) begin
              d_ack   <= 1'b1;
              d_rdata <= '0;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= '0;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        ACK: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_avalon_master.sv
// Scoreboard bench for mips_cpu_avalon_master with a programmable-wait Avalon slave.
module tb_mips_cpu_avalon_master;

`ifdef MIPS_AVALON_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 64;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [3:0]  d_byteenable = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy;
  logic        bus_error;

  mips_cpu_avalon_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_byteenable(d_byteenable),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .busy(busy), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave: stalls wait_target edges per transfer, then completes
  int          wait_target = 0;
  int          wcnt = 0;
  logic [31:0] rdata_val = '0;
  logic        active;
  logic        prev_wait = 1'b0;
  logic        gap_required = 1'b0;
  int          bus_xfers = 0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic [69:0] snap = '0;

  assign active          = avm_read | avm_write;
  assign avm_waitrequest = active && (wcnt != wait_target);
  assign avm_readdata    = rdata_val;

  always @(posedge clk) begin
    if (!reset_n) begin
      wcnt <= 0; prev_wait <= 1'b0; gap_required <= 1'b0;
    end else begin
      wcnt         <= (active && avm_waitrequest) ? wcnt + 1 : 0;
      prev_wait    <= active && avm_waitrequest;
      gap_required <= active && !avm_waitrequest;
      if (active && !avm_waitrequest) begin
        bus_xfers <= bus_xfers + 1;
        if (avm_write) begin
          wr_addr <= avm_address; wr_be <= avm_byteenable; wr_data <= avm_writedata;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
`ifdef MIPS_AVALON_TIMEOUT_EN
      if (prev_wait && active)
`else
      if (prev_wait)
`endif
        check("hold_during_wait",
              {avm_address, avm_byteenable, avm_read, avm_write, avm_writedata}, snap);
      if (gap_required) check("idle_gap", active, 1'b0);
      snap <= {avm_address, avm_byteenable, avm_read, avm_write, avm_writedata};
    end
  end

  typedef struct packed {
    logic        is_data;
    logic [31:0] rdata;
    logic        berr;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (reset_n && (i_ack || d_ack)) begin
      check("ack_exclusive", i_ack & d_ack, 1'b0);
      if (sb.size() == 0) begin
        check("unexpected_ack", {i_ack, d_ack}, 2'b00);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_client", d_ack, e.is_data);
        check("ack_rdata", e.is_data ? d_rdata : i_rdata, e.rdata);
        check("ack_bus_error", bus_error, e.berr);
        $display("[TB] %s ack rdata=%h", e.is_data ? "data " : "fetch", e.is_data ? d_rdata : i_rdata);
      end
    end
  end

  logic [31:0] i_model = '0, d_model = '0;

  task automatic xfer(input bit is_data, input bit we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wdata,
                      input logic [31:0] rd, input int waits);
    int n;
    int lat;
    int xfers0;
    exp_t e;
    @(negedge clk);
    wait_target = waits;
    rdata_val   = rd;
    xfers0      = bus_xfers;
    lat         = (is_data && be == 4'b0000) ? 1 : 2 + waits;
    if (!is_data) i_model = rd;
    else if (!we && be != 4'b0000) d_model = rd;
    e.is_data = is_data;
    e.rdata   = is_data ? d_model : i_model;
    e.berr    = 1'b0;
    sb.push_back(e);
    if (is_data) begin
      d_we = we; d_addr = addr; d_byteenable = be; d_wdata = wdata; d_req = 1'b1;
    end else begin
      i_addr = addr; i_req = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_data ? d_ack : i_ack) && n < 200);
    i_req = 1'b0;
    d_req = 1'b0;
    check("ack_latency", n, lat);
    check("bus_cycles", bus_xfers - xfers0, (is_data && be == 4'b0000) ? 0 : 1);
    if (is_data && we && be != 4'b0000)
      check("write_fields", {wr_addr, wr_be, wr_data}, {addr[31:2], 2'b00, be, wdata});
  endtask

  initial begin
    int ni, nd, n;
    exp_t e;
    #12;
    check("rst_client", {i_ack, i_rdata, d_ack, d_rdata, busy, bus_error}, '0);
    check("rst_avm", {avm_address, avm_byteenable, avm_read, avm_write, avm_writedata}, '0);
    @(negedge clk);
    reset_n = 1'b1;

    // Contention straight after reset: fetch first, then data write
    @(negedge clk);
    wait_target = 0;
    rdata_val   = 32'h11112222;
    i_model     = 32'h11112222;
    e = '{1'b0, 32'h11112222, 1'b0}; sb.push_back(e);
    e = '{1'b1, 32'h0, 1'b0};        sb.push_back(e);
    i_addr = 32'h00400000; i_req = 1'b1;
    d_we = 1'b1; d_addr = 32'h00000200; d_byteenable = 4'b1111; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
    ni = 0; nd = 0; n = 0;
    while ((ni == 0 || nd == 0) && n < 50) begin
      @(negedge clk);
      n++;
      if (i_ack) begin ni = n; i_req = 1'b0; end
      if (d_ack) begin nd = n; d_req = 1'b0; end
    end
    check("contend_fetch_lat", ni, 2);
    check("contend_data_lat", nd, 5);
    check("contend_write", {wr_addr, wr_data}, {32'h00000200, 32'hDEADBEEF});

    xfer(1'b0, 1'b0, 32'hBFC00000, 4'b1111, 32'h0, 32'h24020005, 0);
    xfer(1'b1, 1'b1, 32'h00000013, 4'b0100, 32'h00AB0000, 32'h0, 3);
    xfer(1'b1, 1'b0, 32'h00000106, 4'b1111, 32'h0, 32'hCAFEF00D, 1);
    xfer(1'b1, 1'b0, 32'h00000300, 4'b0000, 32'h0, 32'h55555555, 0);
    check("be0_rdata_kept", d_rdata, 32'hCAFEF00D);

    for (int k = 0; k < 8; k++)
      xfer(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom, 4'($urandom_range(15)),
           $urandom, $urandom, $urandom_range(3));

    // Reset while the slave stalls forever
    @(negedge clk);
    wait_target = 1000;
    i_addr = 32'h00001000; i_req = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_active", {busy, avm_read}, 2'b11);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_client", {i_ack, i_rdata, d_ack, d_rdata, busy, bus_error}, '0);
    check("async_rst_avm", {avm_address, avm_byteenable, avm_read, avm_write, avm_writedata}, '0);
    i_req = 1'b0;
    i_model = '0; d_model = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    xfer(1'b0, 1'b0, 32'h00001004, 4'b1111, 32'h0, 32'h8C420000, 2);

`ifdef MIPS_AVALON_TIMEOUT_EN
    @(negedge clk);
    wait_target = 1000;
    e = '{1'b0, 32'h0, 1'b1}; sb.push_back(e);
    i_addr = 32'h00002000; i_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!i_ack && n < 200);
    i_req = 1'b0;
    check("timeout_lat", n, TO + 1);
    repeat (3) @(negedge clk);
    check("bus_error_sticky", {bus_error, avm_read}, 2'b10);
    #2 reset_n = 1'b0;
    #1 check("bus_error_rst", bus_error, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_cpu_avalon_master.md
# mips_cpu_avalon_master

Bus-master front end of the MIPS CPU: accepts word-level instruction-fetch and data-access requests from the CPU core, arbitrates them onto the single Avalon memory-mapped port, and holds every master signal stable while the slave asserts `avm_waitrequest`. Sits directly upstream of the Avalon RAM/slave and returns read data plus a one-cycle acknowledge to the requesting client.

## Interface
- `TIMEOUT_CYCLES`, 64: consecutive waitrequest-high edges before abort (used only with timeout feature).
- `clk` in 1: system clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `i_req` in 1: fetch request level, held until `i_ack`.
- `i_addr` in 32: fetch byte address.
- `i_ack` out 1: one-cycle pulse, `i_rdata` valid.
- `i_rdata` out 32: fetched word, registered, held until next fetch completes.
- `d_req` in 1: data request level, held until `d_ack`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in 32: data byte address.
- `d_byteenable` in 4: lane enables.
- `d_wdata` in 32: write data.
- `d_ack` out 1: one-cycle pulse, transfer done.
- `d_rdata` out 32: read word, registered, held until next data read completes.
- `avm_address` out 32, `avm_byteenable` out 4, `avm_read` out 1, `avm_write` out 1, `avm_writedata` out 32: Avalon master outputs, all registered.
- `avm_waitrequest` in 1, `avm_readdata` in 32: Avalon slave responses.
- `busy` out 1: high in ISSUE and ACK.
- `bus_error` out 1: sticky timeout flag (constant 0 without timeout feature).

## Operation
- States: IDLE, ISSUE, ACK.
- IDLE: sample `d_req`/`i_req` at edge. None -> stay. One -> grant it. Both -> grant the client not granted last; `last_grant` resets to data, so fetch wins the first contention.
- Grant (IDLE->ISSUE): latch request into Avalon regs. `avm_address = {addr[31:2],2'b00}` (low bits dropped). Fetch: `avm_read=1`, byteenable `4'b1111`. Data: `avm_read=~d_we`, `avm_write=d_we`, byteenable/writedata from client.
- Data request with `d_byteenable==4'b0000`: no bus cycle; IDLE->ACK directly, `d_ack` pulses, `d_rdata` unchanged.
- ISSUE: at each edge, `avm_waitrequest==1` -> hold all avm outputs unchanged. `avm_waitrequest==0` -> transfer complete: for reads capture `avm_readdata` into granted client's rdata reg; clear `avm_read`/`avm_write`; go ACK, asserting granted client's ack.
- ACK: ack high exactly one cycle; -> IDLE. Client must drop or change req on the edge ending ACK; IDLE does not sample during ACK, so no double grant.
- Non-granted request stays pending, unaffected.
- Client inputs are ignored after grant (latched copy used).

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, `last_grant`=data, every output 0 (`avm_*`, acks, rdata regs, `busy`, `bus_error`). In-flight transfer abandoned without ack.
- Min latency: req sampled edge N -> `avm_read/write` high after N -> if waitrequest low at N+1, ack high for cycle after N+1. Each extra waitrequest-high edge adds one cycle.
- Waitrequest may toggle combinationally within a cycle after read/write rise; only its value at the rising edge matters.
- Back-to-back: next grant at earliest the edge after ACK; bus idle (read=write=0) at least one cycle between transfers.

## Configuration
- `MIPS_AVALON_TIMEOUT_EN` defined: 8-bit-min counter clears on entering ISSUE, increments each ISSUE edge with waitrequest high; reaching `TIMEOUT_CYCLES` -> drop read/write, go ACK, pulse ack with rdata reg set to 0, set `bus_error` (sticky until reset).
- Undefined: no counter; ISSUE waits indefinitely; `bus_error` tied 0.

## Test plan
- Fetch, zero wait: `i_addr=32'hBFC00000`, readdata `32'h24020005`, waitrequest low -> `avm_read` one cycle, `i_ack` pulse 2 edges after sampling, `i_rdata=32'h24020005`.
- Data write with 3 wait edges: `d_addr=32'h00000013`, byteenable `4'b0100`, wdata `32'h00AB0000` -> `avm_address=32'h00000010`, signals stable through all wait cycles, `d_ack` after 5 edges.
- Contention after reset: `i_req` and `d_req` high together -> fetch granted first, data second, two ack pulses separated by an idle bus cycle.
- Data read with byteenable `4'b0000` -> no `avm_read`, `d_ack` next cycle, `d_rdata` unchanged.
- Reset mid-ISSUE with waitrequest held high -> all outputs 0 immediately, no ack; subsequent fetch completes normally.
- With `MIPS_AVALON_TIMEOUT_EN`, `TIMEOUT_CYCLES=4`, waitrequest stuck high -> read drops after 4 edges, `i_ack` pulse, `i_rdata=0`, `bus_error=1` until reset.
